// File: rtl/cpu_dmem_sequencer.sv
// Data-memory access sequencer: splits byte/short/long loads and stores into
// big-endian Wishbone classic beats and reports a single completion per request.
module cpu_dmem_sequencer #(
  parameter int BUS_W   = 16,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] dmem_address_o,
  output logic [BUS_W-1:0]  dmem_data_o,
  input  logic [BUS_W-1:0]  dmem_data_i,
  output logic [BUS_W/8-1:0] dmem_sel_o,
  output logic              dmem_cyc_o,
  output logic              dmem_stb_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i,
  input  logic              dmem_err_i
);

  localparam int BPB  = BUS_W / 8;
  localparam int OFFW = $clog2(BPB);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       asm_q, asm_d;
  logic [2:0]        lanes_q, lanes_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  logic [2:0]        reqBytes;
  logic              reqLegal;
  logic [31:0]       reqLeft;
  logic [31:0]       reqRep;
  logic [BUS_W-1:0]  repBeat;

  // Store data is pre-arranged so every beat simply takes the top BUS_W bits:
  // left-justified for multi-beat requests, lane-replicated for narrow ones.
  always_comb begin
    reqBytes = 3'd4;
    reqLegal = 1'b0;
    reqLeft  = req_data_i;
    case (req_size_i)
      2'b00: begin
        reqBytes = 3'd1;
        reqLegal = 1'b1;
        reqLeft  = {req_data_i[7:0], 24'h0};
      end
      2'b01: begin
        reqBytes = 3'd2;
        reqLegal = ~req_addr_i[0];
        reqLeft  = {req_data_i[15:0], 16'h0};
      end
      2'b10: begin
        reqBytes = 3'd4;
        reqLegal = (req_addr_i[1:0] == 2'b00);
        reqLeft  = req_data_i;
      end
      default: begin
        reqBytes = 3'd4;
        reqLegal = 1'b0;
        reqLeft  = req_data_i;
      end
    endcase
    repBeat = '0;
    for (int j = 0; j < BPB; j++) begin
      repBeat[j*8 +: 8] = (req_size_i == 2'b00) ? req_data_i[7:0]
                                                 : req_data_i[(j % 2)*8 +: 8];
    end
    reqRep = '0;
    reqRep[31 -: BUS_W] = repBeat;
  end

  logic [2:0]       laneShift;
  logic [7:0]       laneMask;
  logic [7:0]       selWide;
  logic [BUS_W-1:0] rdShift;
  logic [31:0]      rd32;
  logic [31:0]      rdNew;
  logic [31:0]      asmShift;
  logic             tmrHit;

  // Lowest byte address sits in the highest lane, so the selected lanes start
  // BPB-off-L lanes above lane 0.
  always_comb begin
    laneShift = 3'(BPB) - {1'b0, off_q} - lanes_q;
    case (lanes_q)
      3'd1:    laneMask = 8'h01;
      3'd2:    laneMask = 8'h03;
      default: laneMask = 8'h0F;
    endcase
    selWide = laneMask << laneShift;
    rdShift = dmem_data_i >> {laneShift, 3'b000};
    rd32    = 32'(rdShift);
    case (lanes_q)
      3'd1: begin
        rdNew    = {24'h0, rd32[7:0]};
        asmShift = {asm_q[23:0], 8'h0};
      end
      3'd2: begin
        rdNew    = {16'h0, rd32[15:0]};
        asmShift = {asm_q[15:0], 16'h0};
      end
      default: begin
        rdNew    = rd32;
        asmShift = 32'h0;
      end
    endcase
    tmrHit = (TIMEOUT != 0) && (tmr_q == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wbuf_q  <= '0;
      asm_q   <= '0;
      lanes_q <= '0;
      off_q   <= '0;
      last_q  <= '0;
      k_q     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      asm_q   <= asm_d;
      lanes_q <= lanes_d;
      off_q   <= off_d;
      last_q  <= last_d;
      k_q     <= k_d;
      we_q    <= we_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      tmr_q   <= tmr_d;
    end
  end

  // Illegal requests skip BEAT entirely and report an error straight from RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    asm_d   = asm_q;
    lanes_d = lanes_q;
    off_d   = off_q;
    last_d  = last_q;
    k_d     = k_q;
    we_d    = we_q;
    err_d   = err_q;
    drop_d  = drop_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          addr_d  = req_addr_i & ~ADDR_W'(BPB - 1);
          off_d   = req_addr_i[1:0] & 2'(BPB - 1);
          lanes_d = (reqBytes < 3'(BPB)) ? reqBytes : 3'(BPB);
          last_d  = (reqBytes > 3'(BPB)) ? 2'((reqBytes >> OFFW) - 3'd1) : 2'd0;
          wbuf_d  = (reqBytes < 3'(BPB)) ? reqRep : reqLeft;
          asm_d   = '0;
          k_d     = '0;
          tmr_d   = '0;
          we_d    = req_we_i;
          err_d   = ~reqLegal;
          drop_d  = 1'b0;
          state_d = reqLegal ? BEAT : RESP;
        end
      end
      BEAT: begin
        if (flush_i && !we_q) drop_d = 1'b1;
        if (dmem_err_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (dmem_ack_i) begin
          asm_d = asmShift | rdNew;
          if (k_q == last_q) begin
            state_d = RESP;
          end else begin
            k_d    = k_q + 2'd1;
            addr_d = addr_q + ADDR_W'(BPB);
            wbuf_d = wbuf_q << BUS_W;
            tmr_d  = '0;
          end
        end else if (tmrHit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic showResp;

  // A flush landing on the response cycle itself still suppresses a load.
  always_comb begin
    req_ready_o    = (state_q == IDLE) && !rst_i;
    busy_o         = (state_q != IDLE);
    dmem_cyc_o     = 1'b0;
    dmem_stb_o     = 1'b0;
    dmem_we_o      = 1'b0;
    dmem_address_o = '0;
    dmem_data_o    = '0;
    dmem_sel_o     = '0;
    resp_valid_o   = 1'b0;
    resp_err_o     = 1'b0;
    resp_data_o    = '0;
    showResp       = we_q || !(drop_q || flush_i);
    case (state_q)
      BEAT: begin
        dmem_cyc_o     = 1'b1;
        dmem_stb_o     = 1'b1;
        dmem_we_o      = we_q;
        dmem_address_o = addr_q;
        dmem_sel_o     = selWide[BPB-1:0];
        dmem_data_o    = we_q ? wbuf_q[31 -: BUS_W] : '0;
      end
      RESP: begin
        resp_valid_o = showResp;
        resp_err_o   = showResp && err_q;
        resp_data_o  = (showResp && !we_q) ? asm_q : 32'h0;
      end
      default: ;
    endcase
  end

endmodule
